dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-ported data memory between two requesters: port 0 (load/store
//  unit) and port 1 (debug/DMA loader). Per-port req/ack handshake; requests latched
//  on grant; one access drives memory control/address/data lines per transaction.
//  Memory read data is registered (valid the cycle after the access edge).
// PARAMETERS
//  ADDR_W  64  address width, forwarded unchanged to memory
//  DATA_W  64  data width
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high reset
//  req0/req1    in   1       port request; held high until ack seen
//  we0/we1      in   1       1=write, 0=read
//  addr0/addr1  in   ADDR_W  port address
//  wdata0/1     in   DATA_W  port write data
//  ack0/ack1    out  1       one-cycle completion pulse
//  rdata        out  DATA_W  read data, valid only while ack0|ack1 and op was a read
//  busy         out  1       FSM not IDLE
//  mem_addr     out  ADDR_W  to memory Address
//  mem_wdata    out  DATA_W  to memory WData
//  mem_write    out  1       to memory Mwrite
//  mem_read     out  1       to memory Mread
//  mem_rdata    in   DATA_W  from memory RData
// BEHAVIOUR
//  - Reset (async): state=IDLE; ack0/1, busy, mem_write, mem_read=0; mem_addr,
//    mem_wdata, rdata=0; round-robin pointer last=1 (port 0 wins first).
//  - FSM: IDLE -> ISSUE -> RESP -> IDLE. No arbitration in ISSUE or RESP.
//  - IDLE: at edge with any req high, choose winner, latch its we/addr/wdata into
//    internal regs, record grant id, go ISSUE. No req: stay IDLE.
//  - Arbitration (round-robin): both requesting -> port != last; one -> that port.
//    last updated to winner at grant.
//  - ISSUE (1 cycle): mem_addr/mem_wdata from latched regs; mem_write=we,
//    mem_read=!we; memory acts on edge ending ISSUE. Go RESP.
//  - RESP (1 cycle): mem_write=mem_read=0; ack of granted port=1; rdata=mem_rdata
//    (combinational pass-through) for reads, 0 for writes. Go IDLE.
//  - Latency: req sampled at edge E0 -> ack high in cycle after E1 -> one
//    transaction per 3 cycles per port max. Requester drops req or presents a new
//    request after sampling ack; request present in IDLE is a new transaction.
//  - Requester may change addr/wdata/we after grant edge; latched copy is used.
//  - Never both acks high; never mem_write and mem_read high together.
//  - Losing requester's req stays pending; serviced at next IDLE.
//  - Reset mid-ISSUE: memory controls drop immediately; access not guaranteed done.
//    Reset mid-RESP: ack cleared; requester must reissue.
//  - Address not range-checked; width conversion none (pass-through).
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: fixed priority, port 0 always wins ties; last unused.
//  Not defined (default): round-robin as above.
// TESTING
//  1 Reset mid-op: assert reset in ISSUE -> mem_write/mem_read/ack/busy=0 same cycle.
//  2 Single read: req0, we0=0, addr0=5 (mem[5]=5) -> mem_read=1 in ISSUE,
//    ack0=1 with rdata=5 two cycles after grant edge; ack1 stays 0.
//  3 Write then read: port1 write addr 10 data 0xDEAD, then port1 read addr 10
//    -> second ack1 with rdata=0xDEAD; exactly one mem_write pulse.
//  4 Contention (RR): req0&req1 held from reset -> grants 0,1,0,1; acks alternate
//    every 3 cycles; no cycle with both acks.
//  5 Contention with ARB_FIXED_PRIO_EN: req0 re-requests each IDLE -> port 1
//    starved; drop req0 -> port 1 acked within 3 cycles.
//  6 Latch check: change addr0 from 7 to 9 in ISSUE -> mem_addr=7, rdata=mem[7].

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Request/acknowledge and memory-side bundle for the two-port data memory arbiter.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata, busy, mem_addr, mem_wdata, mem_write, mem_read
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata, busy, mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-ported data memory: IDLE -> ISSUE -> RESP per access.
// Define ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module dmem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_r;
  logic              gid_r;
  logic              we_r;
  logic              ack0_r;
  logic              ack1_r;
  logic              busy_r;
  logic              mem_write_r;
  logic              mem_read_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] rdata_s;
  logic              win_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
`ifndef ARB_FIXED_PRIO_EN
  logic              last_r;
`endif

  // Winner selection for the grant edge
  always_comb begin
    win_s = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    if (bus.req0) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
`else
    if (bus.req0 && bus.req1) begin
      win_s = ~last_r;
    end else if (bus.req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
`endif
  end

  // Mux of the winning port's request fields
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (win_s) begin
      sel_we_s    = bus.we1;
      sel_addr_s  = bus.addr1;
      sel_wdata_s = bus.wdata1;
    end else begin
      sel_we_s    = bus.we0;
      sel_addr_s  = bus.addr0;
      sel_wdata_s = bus.wdata0;
    end
  end

  // Arbitration FSM with registered handshake and memory controls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      gid_r       <= 1'b0;
      we_r        <= 1'b0;
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      busy_r      <= 1'b0;
      mem_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_r      <= 1'b1;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            // mem_addr/mem_wdata double as the latched request copy
            state_r     <= ISSUE;
            gid_r       <= win_s;
            we_r        <= sel_we_s;
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
            mem_write_r <= sel_we_s;
            mem_read_r  <= ~sel_we_s;
            busy_r      <= 1'b1;
`ifndef ARB_FIXED_PRIO_EN
            last_r      <= win_s;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          state_r     <= RESP;
          mem_write_r <= 1'b0;
          mem_read_r  <= 1'b0;
          ack0_r      <= ~gid_r;
          ack1_r      <= gid_r;
        end
        RESP: begin
          state_r <= IDLE;
          ack0_r  <= 1'b0;
          ack1_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          ack0_r      <= 1'b0;
          ack1_r      <= 1'b0;
          busy_r      <= 1'b0;
          mem_write_r <= 1'b0;
          mem_read_r  <= 1'b0;
        end
      endcase
    end
  end

  // Memory read data is already registered, so it passes straight through in RESP
  always_comb begin
    rdata_s = '0;
    if ((state_r == RESP) && !we_r) begin
      rdata_s = bus.mem_rdata;
    end else begin
      rdata_s = '0;
    end
  end

  assign bus.ack0      = ack0_r;
  assign bus.ack1      = ack1_r;
  assign bus.busy      = busy_r;
  assign bus.rdata     = rdata_s;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_write = mem_write_r;
  assign bus.mem_read  = mem_read_r;

endmodule

// Protocol invariants of the arbiter outputs.
module dmem_arbiter_checker (
  input logic clk,
  input logic reset,
  input logic ack0,
  input logic ack1,
  input logic busy,
  input logic mem_write,
  input logic mem_read
);

  a_one_ack : assert property (@(posedge clk) disable iff (reset) !(ack0 && ack1));
  a_one_ctl : assert property (@(posedge clk) disable iff (reset) !(mem_write && mem_read));
  a_ack_busy : assert property (@(posedge clk) disable iff (reset) (ack0 || ack1) |-> busy);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level reference model.
// Honours ARB_FIXED_PRIO_EN the same way the design does.
module tb_dmem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dmem_arbiter_checker chk (
    .clk       (clk),
    .reset     (reset),
    .ack0      (bus.ack0),
    .ack1      (bus.ack1),
    .busy      (bus.busy),
    .mem_write (bus.mem_write),
    .mem_read  (bus.mem_read)
  );

  // Memory device: registered read data, write on the access edge
  logic [DW-1:0] dev_mem [16];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) dev_mem[i] <= DW'(i);
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_write) dev_mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
      if (bus.mem_read) bus.mem_rdata <= dev_mem[bus.mem_addr[3:0]];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side stimulus
  logic          r [2];
  logic          w [2];
  logic [AW-1:0] a [2];
  logic [DW-1:0] d [2];
  bit            granted [2];
  int            pct;

  // Reference model state
  logic [DW-1:0] ref_mem [16];
  int            to_free;
  bit            gid;
  bit            g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
`ifndef ARB_FIXED_PRIO_EN
  bit            last;
`endif
  bit            e_ack [2];
  bit            e_busy, e_rd, e_wr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;

  task automatic apply_inputs();
    bus.req0 = r[0];   bus.req1 = r[1];
    bus.we0 = w[0];    bus.we1 = w[1];
    bus.addr0 = a[0];  bus.addr1 = a[1];
    bus.wdata0 = d[0]; bus.wdata1 = d[1];
  endtask

  task automatic drive();
    for (int p = 0; p < 2; p++) begin
      if (!r[p] || e_ack[p]) begin
        granted[p] = 1'b0;
        if (int'($urandom_range(99)) < pct) begin
          r[p] = 1'b1;
          w[p] = 1'($urandom_range(1));
          a[p] = AW'($urandom_range(15));
          d[p] = {$urandom(), $urandom()};
        end else begin
          r[p] = 1'b0;
        end
      end else if (granted[p]) begin
        // already latched by the arbiter: scramble the live copy
        w[p] = 1'($urandom_range(1));
        a[p] = AW'($urandom_range(15));
        d[p] = {$urandom(), $urandom()};
      end
    end
    apply_inputs();
  endtask

  // Predict outputs after the next rising edge from the transaction rules
  task automatic model_edge();
    e_ack[0] = 1'b0; e_ack[1] = 1'b0;
    e_rd = 1'b0; e_wr = 1'b0; e_rdata = '0;
    if (to_free == 2) begin
      to_free = 1;
      e_busy = 1'b1;
      e_ack[gid] = 1'b1;
      if (g_we) ref_mem[g_addr[3:0]] = g_wdata;
      else e_rdata = ref_mem[g_addr[3:0]];
    end else if (to_free == 1) begin
      to_free = 0;
      e_busy = 1'b0;
    end else if (r[0] || r[1]) begin
`ifdef ARB_FIXED_PRIO_EN
      gid = r[0] ? 1'b0 : 1'b1;
`else
      if (r[0] && r[1]) gid = ~last;
      else gid = r[1];
      last = gid;
`endif
      g_we = w[gid]; g_addr = a[gid]; g_wdata = d[gid];
      granted[gid] = 1'b1;
      to_free = 2;
      e_busy = 1'b1;
      e_rd = ~g_we; e_wr = g_we;
      e_addr = g_addr; e_wdata = g_wdata;
    end else begin
      e_busy = 1'b0;
    end
  endtask

  task automatic compare();
    check_val("ack0", 64'(bus.ack0), 64'(e_ack[0]));
    check_val("ack1", 64'(bus.ack1), 64'(e_ack[1]));
    check_val("busy", 64'(bus.busy), 64'(e_busy));
    check_val("mem_read", 64'(bus.mem_read), 64'(e_rd));
    check_val("mem_write", 64'(bus.mem_write), 64'(e_wr));
    if (e_rd || e_wr) check_val("mem_addr", bus.mem_addr, e_addr);
    if (e_wr) check_val("mem_wdata", bus.mem_wdata, e_wdata);
    if ((e_ack[0] || e_ack[1]) && !g_we) check_val("rdata", bus.rdata, e_rdata);
  endtask

  task automatic step();
    drive();
    model_edge();
    @(negedge clk);
    compare();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    for (int p = 0; p < 2; p++) begin
      r[p] = 1'b0; w[p] = 1'b0; a[p] = '0; d[p] = '0; granted[p] = 1'b0;
      e_ack[p] = 1'b0;
    end
    apply_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ack0", 64'(bus.ack0), 64'd0);
    check_val("rst_ack1", 64'(bus.ack1), 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_mem_read", 64'(bus.mem_read), 64'd0);
    check_val("rst_mem_write", 64'(bus.mem_write), 64'd0);
    check_val("rst_mem_addr", bus.mem_addr, 64'd0);
    check_val("rst_mem_wdata", bus.mem_wdata, 64'd0);
    check_val("rst_rdata", bus.rdata, 64'd0);

    for (int i = 0; i < 16; i++) ref_mem[i] = DW'(i);
    to_free = 0;
    e_busy = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    last = 1'b1;
`endif
    reset = 1'b0;

    // Sparse traffic, then permanent contention on both ports
    pct = 50;
    for (int c = 0; c < 600; c++) begin
      if (c == 300) pct = 100;
      step();
    end
    pct = 30;
    for (int c = 0; c < 200; c++) step();

    // Reset while an access is on the memory bus
    pct = 100;
    n = 0;
    while (!(e_rd || e_wr) && n < 10) begin
      step();
      n++;
    end
    check_val("issue_reached", 64'(e_rd || e_wr), 64'd1);
    reset = 1'b1;
    #1;
    check_val("midrst_mem_read", 64'(bus.mem_read), 64'd0);
    check_val("midrst_mem_write", 64'(bus.mem_write), 64'd0);
    check_val("midrst_ack0", 64'(bus.ack0), 64'd0);
    check_val("midrst_ack1", 64'(bus.ack1), 64'd0);
    check_val("midrst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
